// File: rtl/dot_matrix_scheduler.sv
//==============================================================================
// Module   : dot_matrix_scheduler
// Purpose  : Row-scan scheduler for an 8x8 LED dot matrix composed of two
//            layers (l0 = obstacles, l1 = player). For each row it fetches
//            both layers, shows their OR for DWELL cycles, then blanks for
//            one cycle before moving on to the next row.
// Ports    : clk, reset (async, active-low)
//            enable        - scan runs while high; a drop takes effect at BLANK
//            fetch_req     - level request to both layers for row scan_row
//            scan_row[2:0] - row being fetched / shown
//            l0_data/l1_data[7:0], l0_valid/l1_valid - layer responses
//            row[7:0]      - active-low one-hot row drive (8'hFF = all off)
//            col[7:0]      - active-high column drive
//            frame_done    - one-cycle pulse in the BLANK after row 7
//            stale         - sticky: a layer fetch timed out
//            clear         - synchronous clear of sticky flags
//            collision     - (COLLISION_DETECT_EN only) sticky layer overlap
// Config   : define COLLISION_DETECT_EN to add the collision output.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module dot_matrix_scheduler #(
  parameter int DWELL   = 50000,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       fetch_req,
  output logic [2:0] scan_row,
  input  logic [7:0] l0_data,
  input  logic [7:0] l1_data,
  input  logic       l0_valid,
  input  logic       l1_valid,
  output logic [7:0] row,
  output logic [7:0] col,
  output logic       frame_done,
  output logic       stale,
  input  logic       clear
`ifdef COLLISION_DETECT_EN
  , output logic     collision
`endif
);

  localparam int DW = $clog2(DWELL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;
  localparam logic [1:0] BLANK = 2'd3;

  logic [1:0]    state;
  logic [7:0]    l0_lat, l1_lat;
  logic          got0, got1;
  logic [TW-1:0] fetch_cnt;
  logic [DW-1:0] dwell_cnt;

  // A layer is captured only on its first valid of the current fetch; later
  // valids in the same fetch and any valid outside FETCH are ignored.
  logic       take0, take1;
  logic       got0_next, got1_next;
  logic [7:0] l0_next, l1_next;
  logic       both_next;
  logic       fetch_timeout;
  logic       fetch_exit;
  logic       dwell_last;
  logic [7:0] show_row;

  assign take0     = (state == FETCH) && l0_valid && !got0;
  assign take1     = (state == FETCH) && l1_valid && !got1;
  assign got0_next = got0 | take0;
  assign got1_next = got1 | take1;
  assign l0_next   = take0 ? l0_data : l0_lat;
  assign l1_next   = take1 ? l1_data : l1_lat;
  assign both_next = got0_next & got1_next;

  // fetch_cnt counts completed FETCH cycles, so the TIMEOUT-th cycle is the last.
  assign fetch_timeout = (fetch_cnt == TW'(TIMEOUT - 1));
  assign fetch_exit    = (state == FETCH) && (both_next || fetch_timeout);
  assign dwell_last    = (dwell_cnt == DW'(DWELL - 1));
  assign show_row      = ~(8'd1 << scan_row);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      scan_row   <= 3'd0;
      row        <= 8'hFF;
      col        <= 8'h00;
      fetch_req  <= 1'b0;
      frame_done <= 1'b0;
      l0_lat     <= 8'h00;
      l1_lat     <= 8'h00;
      got0       <= 1'b0;
      got1       <= 1'b0;
      fetch_cnt  <= '0;
      dwell_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          row       <= 8'hFF;
          col       <= 8'h00;
          fetch_req <= 1'b0;
          if (enable) begin
            state     <= FETCH;
            fetch_req <= 1'b1;
            l0_lat    <= 8'h00;
            l1_lat    <= 8'h00;
            got0      <= 1'b0;
            got1      <= 1'b0;
            fetch_cnt <= '0;
          end
        end
        FETCH: begin
          l0_lat <= l0_next;
          l1_lat <= l1_next;
          got0   <= got0_next;
          got1   <= got1_next;
          if (fetch_exit) begin
            // An unfetched layer still holds the 8'h00 loaded on FETCH entry.
            state     <= SHOW;
            fetch_req <= 1'b0;
            row       <= show_row;
            col       <= l0_next | l1_next;
            dwell_cnt <= '0;
          end else begin
            fetch_cnt <= fetch_cnt + TW'(1);
          end
        end
        SHOW: begin
          if (dwell_last) begin
            state      <= BLANK;
            row        <= 8'hFF;
            col        <= 8'h00;
            frame_done <= (scan_row == 3'd7);
          end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end
        end
        BLANK: begin
          scan_row <= scan_row + 3'd1;
          if (enable) begin
            state     <= FETCH;
            fetch_req <= 1'b1;
            l0_lat    <= 8'h00;
            l1_lat    <= 8'h00;
            got0      <= 1'b0;
            got1      <= 1'b0;
            fetch_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as clear wins.
  logic stale_set;
  assign stale_set = fetch_exit && !both_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stale <= 1'b0;
    end else begin
      stale <= stale_set | (stale & ~clear);
    end
  end

`ifdef COLLISION_DETECT_EN
  logic coll_set;
  assign coll_set = fetch_exit && ((l0_next & l1_next) != 8'h00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collision <= 1'b0;
    end else begin
      collision <= coll_set | (collision & ~clear);
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/dot_matrix_scheduler.md
DOT_MATRIX_SCHEDULER -- requirements
Module: dot_matrix_scheduler

Interface
REQ-001 Parameter DWELL, default 50000: clk cycles each row is lit.
REQ-002 Parameter TIMEOUT, default 16: max clk cycles to wait for a layer fetch.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = scan runs; 0 = finish current row, then idle blanked.
REQ-006 fetch_req  output  1  level request to both layers for row scan_row.
REQ-007 scan_row  output  3  row index being fetched/shown, 0..7.
REQ-008 l0_data, l1_data  input  8 each  layer column bits (obstacles, player), 1 = pixel lit.
REQ-009 l0_valid, l1_valid  input  1 each  layer data valid for current fetch.
REQ-010 row  output  8  active-low one-hot row drive; 8'hFF = all off.
REQ-011 col  output  8  active-high column drive.
REQ-012 frame_done  output  1  one-cycle pulse after row 7 finishes SHOW.
REQ-013 stale  output  1  sticky: some fetch timed out; cleared by clear.
REQ-014 clear  input  1  synchronous clear of sticky flags.

Function
REQ-015 FSM states IDLE, FETCH, SHOW, BLANK; SHALL be the only states.
REQ-016 IDLE: row=8'hFF, col=0, fetch_req=0; enable=1 -> FETCH with scan_row unchanged.
REQ-017 FETCH: fetch_req=1; each valid latches its data at most once per fetch; both latched -> SHOW next cycle.
REQ-018 FETCH lasting TIMEOUT cycles without both valid -> SHOW; unlatched layer uses 8'h00; stale set.
REQ-019 valid asserted outside FETCH SHALL be ignored.
REQ-020 SHOW: row = ~(8'b1 << scan_row), col = l0_latched | l1_latched, held exactly DWELL cycles; fetch_req=0.
REQ-021 BLANK: exactly 1 cycle, row=8'hFF, col=0; scan_row increments, wrapping 7 -> 0.
REQ-022 frame_done pulses in the BLANK cycle leaving row 7.
REQ-023 BLANK -> FETCH if enable=1, else IDLE; enable deassert during FETCH/SHOW takes effect only at BLANK.
REQ-024 Dwell counter width ceil(log2(DWELL+1)); wraps to 0 at each SHOW entry.
REQ-025 clear and a simultaneous set event: set wins.
REQ-026 row/col registered; no combinational path from inputs to row/col.

Reset
REQ-027 reset low, asynchronously: state=IDLE, scan_row=0, row=8'hFF, col=0, fetch_req=0, frame_done=0, stale=0, latches=0, counters=0.
REQ-028 reset asserted mid-row SHALL blank outputs immediately; release resumes from row 0.

Configuration
REQ-029 Macro COLLISION_DETECT_EN defined: add output collision (1, sticky) set in the FETCH->SHOW transition cycle when (l0_latched & l1_latched) != 0; cleared by clear; reset 0.
REQ-030 Macro undefined: no collision port or logic; all other behaviour identical.

Verification
REQ-031 Reset, enable=1, both layers valid 1 cycle after req with l0=8'hC0, l1=8'h10 -> row0 shows row=8'hFE, col=8'hD0 for DWELL cycles.
REQ-032 Full frame rows 0..7 -> row one-hot walks FE,FD,...,7F; one BLANK (FF) between rows; single frame_done after row 7; scan_row wraps to 0.
REQ-033 l1_valid never asserted, TIMEOUT=16 -> SHOW entered 16 cycles after fetch_req, col=l0 only, stale=1; clear=1 -> stale=0.
REQ-034 enable dropped mid-SHOW of row 3 -> row 3 completes, BLANK, IDLE with row=FF, scan_row=4; re-enable fetches row 4.
REQ-035 reset pulled low mid-SHOW -> row=FF, col=0 same cycle; after release scan restarts at row 0.
REQ-036 With COLLISION_DETECT_EN, l0=8'h30, l1=8'h10 -> collision=1 and stays set until clear; l0=8'hC0, l1=8'h10 -> stays 0.
